// File: rtl/muldiv_pkg.sv
// Shared op encodings, state encoding and default width for the mul/div unit.
// Optional build macro: MULDIV_EARLY_OUT_EN (zero-operand early completion).
package muldiv_pkg;

    localparam int WIDTH_DEF = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t CALC = 2'd1;
    localparam state_t FIX  = 2'd2;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned core: shift-add multiply or
// restoring shift-subtract divide, selected by is_div.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] sh,
    input  logic [WIDTH-1:0] mag,
    output logic [WIDTH-1:0] acc_n,
    output logic [WIDTH-1:0] sh_n
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem2;
    logic [WIDTH:0] diff;
    logic           ge;

    always_comb begin
        sum  = {1'b0, acc} + (sh[0] ? {1'b0, mag} : '0);
        rem2 = {acc, sh[WIDTH-1]};
        diff = rem2 - {1'b0, mag};
        ge   = (rem2 >= {1'b0, mag});
        if (is_div) begin
            // Remainder stays below the divisor, so diff fits in WIDTH bits.
            acc_n = ge ? diff[WIDTH-1:0] : rem2[WIDTH-1:0];
            sh_n  = {sh[WIDTH-2:0], ge};
        end else begin
            acc_n = sum[WIDTH:1];
            sh_n  = {sum[0], sh[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit holding the HI/LO registers.
// Build macro MULDIV_EARLY_OUT_EN skips CALC when an operand is zero.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             is_div_q;
    logic             neg_res;
    logic             neg_rem;
    logic             dz;
    logic [WIDTH-1:0] rs_q;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] mag;
    logic [WIDTH-1:0] acc_n;
    logic [WIDTH-1:0] sh_n;

    logic             is_div;
    logic             sgn_op;
    logic             rs_neg;
    logic             rt_neg;
    logic [WIDTH-1:0] rs_mag;
    logic [WIDTH-1:0] rt_mag;

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    assign busy = (state != IDLE);

    always_comb begin
        is_div = op[1];
        sgn_op = ~op[0];
        rs_neg = sgn_op & rs_data[WIDTH-1];
        rt_neg = sgn_op & rt_data[WIDTH-1];
        rs_mag = rs_neg ? -rs_data : rs_data;
        rt_mag = rt_neg ? -rt_data : rt_data;
    end

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .is_div (is_div_q),
        .acc    (acc),
        .sh     (sh),
        .mag    (mag),
        .acc_n  (acc_n),
        .sh_n   (sh_n)
    );

    // MIN_INT / -1 needs no special case: the magnitude quotient
    // 0x80..0 negates back onto itself and the remainder is zero.
    always_comb begin
        prod = {acc, sh};
        if (neg_res)
            prod = -prod;
        quo = neg_res ? -sh : sh;
        rem = neg_rem ? -acc : acc;
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        unique case (1'b1)
            dz: begin
                res_hi = rs_q;
                res_lo = '1;
            end
            (is_div_q & ~dz): begin
                res_hi = rem;
                res_lo = quo;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            is_div_q <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            dz       <= 1'b0;
            rs_q     <= '0;
            acc      <= '0;
            sh       <= '0;
            mag      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (hi_we)
                        hi <= wdata;
                    if (lo_we)
                        lo <= wdata;
                    if (start) begin
                        is_div_q <= is_div;
                        neg_res  <= rs_neg ^ rt_neg;
                        neg_rem  <= rs_neg;
                        dz       <= is_div & (rt_data == '0);
                        rs_q     <= rs_data;
                        acc      <= '0;
                        sh       <= is_div ? rs_mag : rt_mag;
                        mag      <= is_div ? rt_mag : rs_mag;
                        cnt      <= '0;
`ifdef MULDIV_EARLY_OUT_EN
                        if (rs_data == '0 || rt_data == '0) begin
                            sh    <= '0;
                            state <= FIX;
                        end else begin
                            state <= CALC;
                        end
`else
                        state <= CALC;
`endif
                    end
                end
                CALC: begin
                    acc <= acc_n;
                    sh  <= sh_n;
                    if (cnt == CW'(WIDTH - 1)) begin
                        cnt   <= '0;
                        state <= FIX;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FIX: begin
                    hi    <= res_hi;
                    lo    <= res_lo;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
// Expected latencies follow MULDIV_EARLY_OUT_EN when it is defined.
module tb_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int vectors;
    int miscompares;

    localparam int LAT = 33;
`ifdef MULDIV_EARLY_OUT_EN
    localparam int LAT_Z = 1;
`else
    localparam int LAT_Z = 33;
`endif

    muldiv_unit #(
        .WIDTH (32)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .hi_we   (hi_we),
        .lo_we   (lo_we),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b);
        start   = 1'b1;
        op      = o;
        rs_data = a;
        rt_data = b;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic wait_done(output int n, output int bc);
        n  = 0;
        bc = 0;
        while (done !== 1'b1 && n < 200) begin
            if (busy === 1'b1)
                bc++;
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n;
        int bc;
        int dcnt;
        vectors     = 0;
        miscompares = 0;
        rst     = 1'b0;
        start   = 1'b0;
        op      = 2'b00;
        rs_data = '0;
        rt_data = '0;
        hi_we   = 1'b0;
        lo_we   = 1'b0;
        wdata   = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        launch(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(n, bc);
        chk("multu_lat", 32'(n), 32'(LAT));
        chk("multu_busy", 32'(bc), 32'd33);
        chk("multu_hi", hi, 32'hFFFFFFFE);
        chk("multu_lo", lo, 32'h00000001);
        @(negedge clk);
        chk("done_pulse", {31'd0, done}, 32'd0);

        launch(2'b00, 32'hFFFFFFFD, 32'd7);
        wait_done(n, bc);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFEB);

        launch(2'b10, 32'hFFFFFFF9, 32'd2);
        wait_done(n, bc);
        chk("div_lo", lo, 32'hFFFFFFFD);
        chk("div_hi", hi, 32'hFFFFFFFF);

        launch(2'b11, 32'd100, 32'd7);
        wait_done(n, bc);
        chk("divu_lo", lo, 32'd14);
        chk("divu_hi", hi, 32'd2);
        launch(2'b10, 32'h00001234, 32'd0);
        chk("b2b_done_low", {31'd0, done}, 32'd0);
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        wait_done(n, bc);
        chk("dz_lat", 32'(n), 32'(LAT_Z));
        chk("dz_lo", lo, 32'hFFFFFFFF);
        chk("dz_hi", hi, 32'h00001234);

        launch(2'b10, 32'h80000000, 32'hFFFFFFFF);
        wait_done(n, bc);
        chk("ovf_lo", lo, 32'h80000000);
        chk("ovf_hi", hi, 32'h00000000);
        hi_we = 1'b1;
        wdata = 32'hA5A5A5A5;
        @(negedge clk);
        hi_we = 1'b0;
        chk("mthi_hi", hi, 32'hA5A5A5A5);
        chk("mthi_lo", lo, 32'h80000000);
        lo_we = 1'b1;
        wdata = 32'h0F0F0F0F;
        @(negedge clk);
        lo_we = 1'b0;
        chk("mtlo_lo", lo, 32'h0F0F0F0F);
        chk("mtlo_hi", hi, 32'hA5A5A5A5);

        launch(2'b01, 32'd5, 32'd6);
        repeat (10) @(negedge clk);
        start   = 1'b1;
        op      = 2'b11;
        rs_data = 32'd77;
        rt_data = 32'd3;
        hi_we   = 1'b1;
        wdata   = 32'hDEADBEEF;
        @(negedge clk);
        start   = 1'b0;
        hi_we   = 1'b0;
        chk("busy_we_ign", hi, 32'hA5A5A5A5);
        wait_done(n, bc);
        chk("ign_lat", 32'(n + 11), 32'(LAT));
        chk("ign_hi", hi, 32'd0);
        chk("ign_lo", lo, 32'd30);
        @(negedge clk);
        chk("ign_idle", {31'd0, busy}, 32'd0);

        launch(2'b11, 32'd1000, 32'd3);
        repeat (12) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_hi", hi, 32'd0);
        chk("mid_rst_lo", lo, 32'd0);
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1)
                dcnt++;
            @(negedge clk);
        end
        chk("no_late_done", 32'(dcnt), 32'd0);
        chk("no_late_lo", lo, 32'd0);

        launch(2'b11, 32'd9, 32'd4);
        wait_done(n, bc);
        chk("post_rst_lat", 32'(n), 32'(LAT));
        chk("post_rst_lo", lo, 32'd2);
        chk("post_rst_hi", hi, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
